// File: rtl/mult_wb_pkg.sv
// Definitions shared by the multiplier's Wishbone slave wrapper and the initiator.
// Covers the register map, widths, the unmapped-read sentinel and the initiator FSM states.
package mult_wb_pkg;

    localparam int OP_W   = 16;
    localparam int PROD_W = 32;

    localparam logic [7:0] A_OFF = 8'h00;
    localparam logic [7:0] B_OFF = 8'h04;
    localparam logic [7:0] P_OFF = 8'h08;

    localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        WR_B,
        RD_P,
        RESP
    } mult_state_e;

    // Register offset targeted by the bus cycle that a given state performs.
    function automatic logic [7:0] state_off(input mult_state_e s);
        case (s)
            WR_A:    return A_OFF;
            WR_B:    return B_OFF;
            default: return P_OFF;
        endcase
    endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Counts strobe cycles that go unacknowledged.
// expired_o is raised on the last cycle a slave may still acknowledge.
module wb_ack_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [7:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_mult_initiator.sv
// Wishbone classic master that writes A and B into the multiplier and reads P.
// The product, or a timeout error, is returned on a valid/ready response port.
module wb_mult_initiator
    import mult_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          TIMEOUT   = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_a,
    input  logic [OP_W-1:0]   cmd_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [PROD_W-1:0] rsp_p,
    output logic              rsp_err,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [31:0]       wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    input  logic [31:0]       wbm_dat_i,
    input  logic              wbm_ack_i,
    output logic              busy
);

    mult_state_e       state_q, state_d;
    logic              cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       adr_q, adr_d, dat_q, dat_d;
    logic [OP_W-1:0]   b_q, b_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [PROD_W-1:0] rsp_p_q, rsp_p_d;
    logic              ack, expired, tmo;

    // An ack only counts while our strobe is up.
    assign ack = stb_q & wbm_ack_i;
    assign tmo = stb_q & ~wbm_ack_i & expired;

    wb_ack_timer #(.TIMEOUT(TIMEOUT)) u_ack_timer (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .clr_i     (~stb_q | wbm_ack_i),
        .en_i      (stb_q & ~wbm_ack_i),
        .expired_o (expired)
    );

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_p_d     = rsp_p_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                // WR_A strobes straight off the handshake; later cycles get a turnaround.
                if (cmd_valid && cmd_ready_q) begin
                    b_d     = cmd_b;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    sel_d   = 4'hF;
                    adr_d   = BASE_ADDR | {24'h0, state_off(WR_A)};
                    dat_d   = {{(32 - OP_W){1'b0}}, cmd_a};
                    state_d = WR_A;
                end
            end
            WR_A, WR_B, RD_P: begin
                if (!stb_q) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    sel_d = 4'hF;
                    we_d  = (state_q != RD_P);
                    adr_d = BASE_ADDR | {24'h0, state_off(state_q)};
                    if (state_q == WR_B) begin
                        dat_d = {{(32 - OP_W){1'b0}}, b_q};
                    end else if (state_q == RD_P) begin
                        dat_d = '0;
                    end
                end else if (ack) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    case (state_q)
                        WR_A:    state_d = WR_B;
                        WR_B:    state_d = RD_P;
                        default: begin
                            state_d     = RESP;
                            rsp_valid_d = 1'b1;
                            rsp_p_d     = wbm_dat_i;
                            rsp_err_d   = 1'b0;
                        end
                    endcase
                end else if (tmo) begin
                    // Abandon the remaining bus cycles and report the error.
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_p_d     = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            b_q         <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_p_q     <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            b_q         <= b_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_p_q     <= rsp_p_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_p     = rsp_p_q;
    assign rsp_err   = rsp_err_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_wb_mult_initiator.sv
// Bench for wb_mult_initiator: behavioural slave with programmable ack latency,
// a per-cycle bus/handshake monitor, and a transaction-level expectation per command.
module tb_wb_mult_initiator;
    import mult_wb_pkg::*;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          TMO  = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [15:0] cmd_a = '0, cmd_b = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_p;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, busy;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_mult_initiator #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
        end
    endfunction

    // Slave: acks on the lat-th strobe cycle of each transaction (lat 0 = never).
    int          lat_wr = 1, lat_rd = 1, scnt = 0, cur_lat;
    bit          spur_en = 0, p_force = 0;
    logic        spur = 1'b0;
    logic [31:0] p_forced = '0;
    logic [15:0] regA = '0, regB = '0;

    always_comb begin
        cur_lat = wbm_we_o ? lat_wr : lat_rd;
        if (wbm_stb_o) wbm_ack_i = (cur_lat != 0) && (scnt == cur_lat - 1);
        else           wbm_ack_i = spur;
        if (wbm_stb_o && !wbm_we_o) wbm_dat_i = p_force ? p_forced : 32'(regA) * 32'(regB);
        else                        wbm_dat_i = 32'h5A5A_A5A5;
    end

    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            scnt <= 0;
        end else if (wbm_stb_o && wbm_ack_i) begin
            scnt <= 0;
            if (wbm_we_o && wbm_adr_o[3:0] == 4'h0) regA <= wbm_dat_o[15:0];
            if (wbm_we_o && wbm_adr_o[3:0] == 4'h4) regB <= wbm_dat_o[15:0];
        end else if (wbm_stb_o) begin
            scnt <= scnt + 1;
        end else begin
            scnt <= 0;
        end
    end

    always @(negedge wb_clk_i) spur <= spur_en && ($urandom_range(0, 2) == 0);

    // Monitor: per-cycle protocol rules plus a log of completed bus transactions.
    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } txn_t;

    txn_t        log_q[$];
    logic        hs_e = 1'b0, rr_e = 1'b0;
    logic        p_stb = 1'b0, p_ack = 1'b0, p_we = 1'b0, p_rv = 1'b0, p_err = 1'b0, ta_w = 1'b0;
    logic [31:0] p_adr = '0, p_dat = '0, p_p = '0;
    int          stb_run = 0, max_run = 0, since_rst = 0;

    always @(posedge wb_clk_i) begin
        hs_e <= cmd_valid && cmd_ready;
        rr_e <= rsp_ready;
    end

    always @(negedge wb_clk_i) begin
        if (wb_rst_i) begin
            p_stb <= 1'b0; p_ack <= 1'b0; p_rv <= 1'b0; ta_w <= 1'b0;
            stb_run <= 0; since_rst <= 0;
        end else begin
            since_rst <= since_rst + 1;
            chk("cyc_eq_stb", wbm_cyc_o, wbm_stb_o);
            if (since_rst > 0) chk("ready_vs_busy", cmd_ready, !busy);
            if (wbm_stb_o) chk("sel", wbm_sel_o, 4'hF);
            if (p_stb && !p_ack && wbm_stb_o) begin
                chk("hold_adr", wbm_adr_o, p_adr);
                chk("hold_we_dat", {wbm_we_o, wbm_dat_o}, {p_we, p_dat});
            end
            if (p_stb && p_ack) chk("turnaround", wbm_cyc_o, 1'b0);
            if (ta_w) chk("one_idle", wbm_stb_o, 1'b1);
            if (p_rv && !rr_e) begin
                chk("rsp_hold_v", rsp_valid, 1'b1);
                chk("rsp_hold_p", rsp_p, p_p);
                chk("rsp_hold_e", rsp_err, p_err);
            end
            if (hs_e) begin
                log_q.delete();
                max_run <= wbm_stb_o ? 1 : 0;
            end else if (wbm_stb_o && stb_run + 1 > max_run) begin
                max_run <= stb_run + 1;
            end
            stb_run <= wbm_stb_o ? stb_run + 1 : 0;
            if (wbm_stb_o && wbm_ack_i) log_q.push_back('{wbm_we_o, wbm_adr_o, wbm_dat_o});
            ta_w  <= p_stb && p_ack && p_we;
            p_stb <= wbm_stb_o; p_ack <= wbm_ack_i; p_we <= wbm_we_o;
            p_adr <= wbm_adr_o; p_dat <= wbm_dat_o;
            p_rv  <= rsp_valid; p_p <= rsp_p; p_err <= rsp_err;
        end
    end

    int          last_cyc;
    logic [31:0] last_p;

    // One command end to end; expectations come from the bus-cycle rules in plain arithmetic.
    task automatic run_cmd(input logic [15:0] a, input logic [15:0] b, input int lw, input int lr,
                           input bit frc, input logic [31:0] fv, input int hold, input bit sp);
        int          lat [3];
        int          exp_cyc, exp_n, exp_run, n, cyc;
        bit          tout;
        logic [31:0] exp_p;
        logic [31:0] e_adr [3];
        logic [31:0] e_dat [3];
        logic        e_we  [3];
        @(negedge wb_clk_i);
        lat_wr = lw; lat_rd = lr; p_force = frc; p_forced = fv; spur_en = sp;
        lat[0] = lw; lat[1] = lw; lat[2] = lr;
        exp_cyc = 1; tout = 0; exp_n = 3; exp_run = 0;
        for (int k = 0; k < 3; k++) begin
            if (lat[k] == 0) begin
                exp_cyc += TMO; tout = 1; exp_n = k; exp_run = TMO;
                break;
            end
            exp_cyc += lat[k] + ((k < 2) ? 1 : 0);
            if (lat[k] > exp_run) exp_run = lat[k];
        end
        exp_p = tout ? 32'h0 : (frc ? fv : 32'(a) * 32'(b));
        e_we[0] = 1'b1; e_adr[0] = BASE + 32'h0; e_dat[0] = {16'h0, a};
        e_we[1] = 1'b1; e_adr[1] = BASE + 32'h4; e_dat[1] = {16'h0, b};
        e_we[2] = 1'b0; e_adr[2] = BASE + 32'h8; e_dat[2] = 32'h0;

        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge wb_clk_i); n++; end
        chk("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0; cmd_a = 16'($urandom); cmd_b = 16'($urandom);
        cyc = 1;
        while (!rsp_valid && cyc < 400) begin @(negedge wb_clk_i); cyc++; end
        chk("rsp_seen", rsp_valid, 1'b1);
        chk("rsp_cycle", cyc, exp_cyc);
        chk("rsp_p", rsp_p, exp_p);
        chk("rsp_err", rsp_err, tout);
        last_cyc = cyc; last_p = rsp_p;
        for (int h = 0; h < hold; h++) begin
            @(negedge wb_clk_i);
            chk("hold_rsp_valid", rsp_valid, 1'b1);
            chk("hold_rsp_p", rsp_p, exp_p);
            chk("hold_cmd_ready", cmd_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready = 1'b0;
        chk("rsp_drop", rsp_valid, 1'b0);
        chk("ready_after_rsp", cmd_ready, 1'b1);
        chk("stb_len", max_run, exp_run);
        chk("txn_count", log_q.size(), exp_n);
        for (int k = 0; k < exp_n && k < log_q.size(); k++) begin
            chk("txn_we_adr", {log_q[k].we, log_q[k].adr}, {e_we[k], e_adr[k]});
            chk("txn_dat", log_q[k].dat, e_dat[k]);
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int   n;
        bit   saw;
        logic [15:0] ra, rb;
        int   lw, lr;

        #12;
        chk("rst_ctrl", {cmd_ready, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, busy}, 0);
        chk("rst_adr", wbm_adr_o, 0);
        chk("rst_dat", wbm_dat_o, 0);
        chk("rst_p", rsp_p, 0);
        @(negedge wb_clk_i); #2 wb_rst_i = 1'b0;
        #1 chk("ready_low_at_release", cmd_ready, 1'b0);
        @(negedge wb_clk_i);
        chk("ready_after_release", cmd_ready, 1'b1);

        run_cmd(16'd3, 16'd5, 1, 1, 0, 0, 0, 0);
        chk("lit_p_3x5", last_p, 32'h0000_000F);
        chk("lit_cyc_6", last_cyc, 6);
        chk("lit_wr_a", log_q.size() > 0 ? log_q[0].dat : 32'hX, 32'h0000_0003);
        chk("lit_wr_b", log_q.size() > 1 ? log_q[1].dat : 32'hX, 32'h0000_0005);

        run_cmd(16'hFFFF, 16'hFFFF, 1, 1, 0, 0, 0, 1);
        chk("lit_p_ffff", last_p, 32'hFFFE_0001);

        run_cmd(16'h1234, 16'h00AB, 3, 3, 0, 0, 0, 1);
        chk("lit_cyc_12", last_cyc, 12);

        run_cmd(16'h0007, 16'h0009, 1, 0, 0, 0, 0, 1);
        chk("lit_tmo_stb16", max_run, 16);
        chk("lit_tmo_p0", last_p, 32'h0);

        run_cmd(16'h0010, 16'h0020, 2, 1, 0, 0, 5, 0);
        run_cmd(16'h0001, 16'h0001, 1, 2, 1, DEADBEEF, 1, 1);
        chk("lit_deadbeef", last_p, 32'hDEAD_BEEF);

        // Reset pulse while WR_B is strobing.
        @(negedge wb_clk_i);
        lat_wr = 3; lat_rd = 1; p_force = 0; spur_en = 0;
        cmd_a = 16'h0042; cmd_b = 16'h0017; cmd_valid = 1'b1;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        n = 0;
        while (!(wbm_stb_o && wbm_adr_o == BASE + 32'h4) && n < 50) begin @(negedge wb_clk_i); n++; end
        chk("reached_wr_b", {wbm_stb_o, wbm_adr_o}, {1'b1, BASE + 32'h4});
        #2 wb_rst_i = 1'b1;
        #1 chk("rst_drops_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 2'b00);
        @(negedge wb_clk_i);
        chk("rst_held_outputs", {cmd_ready, rsp_valid, busy, wbm_cyc_o}, 0);
        #2 wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        chk("ready_after_rst_pulse", cmd_ready, 1'b1);
        saw = 0;
        repeat (20) begin @(negedge wb_clk_i); if (rsp_valid) saw = 1; end
        chk("no_rsp_after_rst", saw, 1'b0);
        run_cmd(16'h0006, 16'h0007, 1, 1, 0, 0, 0, 0);
        chk("lit_p_after_rst", last_p, 32'h0000_002A);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            lw = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 4);
            lr = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 4);
            run_cmd(ra, rb, lw, lr, ($urandom_range(0, 4) == 0), $urandom, $urandom_range(0, 3), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
